// File: rtl/pim_cmp_pkg.sv
// Shared definitions for the PIM column comparators.
//   state_t    : FSM encoding used by the serial comparator (IDLE/RUN/DONE)
//   cnt_width(): bit-counter width for a given operand width
package pim_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // CNT_W helper: $clog2(width), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/subtractor_1bit_cmp.sv
// One-bit compare-subtract cell. It forms the borrow-out of a - b - bin.
// Chained LSB-first, the final borrow is 1 exactly when the unsigned value A < B.
// Ports:
//   a, b  : operand bits of the current position
//   bin   : borrow from the less-significant positions
//   bout  : borrow into the next position
module subtractor_1bit_cmp (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic bout
);

    // b wins when the bits differ; otherwise the lower-order verdict propagates.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/lt_int_bitserial.sv
// Bit-serial less-than comparator, signed or unsigned, for PIM column logic.
// Operands are captured on the input handshake and walked LSB-first, one bit per clock.
// Y = (A < B) is then held on the output handshake until the consumer takes it.
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   A, B                 : operands, sampled on in_valid & in_ready
//   out_valid / out_ready: result handshake (out_valid held until out_ready)
//   Y                    : 1 iff A < B under the SIGNED rule
module lt_int_bitserial
    import pim_cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               y_q, y_d;
    logic               bit_a, bit_b, borrow_nxt;

    assign bit_a = sa_q[0];
    assign bit_b = sb_q[0];

    subtractor_1bit_cmp u_cell (
        .a    (bit_a),
        .b    (bit_b),
        .bin  (borrow_q),
        .bout (borrow_nxt)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        y_d      = y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d     = A;
                    sb_d     = B;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (SIGNED) begin
                        // Differing sign bits decide directly: A negative means A < B.
                        // Equal sign bits leave the magnitude verdict from the lower bits.
                        y_d = (bit_a ^ bit_b) ? bit_a : borrow_q;
                    end else begin
                        y_d = borrow_nxt;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            y_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            y_q      <= y_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign Y         = y_q;

endmodule
